// File: rtl/scan_drv_pkg.sv
// scan_drv_pkg
// Shared definitions for the scan chain driver: the controller state
// encoding and its enumerated type.
package scan_drv_pkg;

  // 2-bit state encodings
  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC   = 2'd1;
  localparam logic [1:0] ST_CAPTURE_ENC = 2'd2;
  localparam logic [1:0] ST_UNLOAD_ENC  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE_ENC,
    SHIFT   = ST_SHIFT_ENC,
    CAPTURE = ST_CAPTURE_ENC,
    UNLOAD  = ST_UNLOAD_ENC
  } state_t;

endpackage

// File: rtl/scan_bit_counter.sv
// scan_bit_counter
// Counts scan shift cycles for one pass over the chain. Saturates at the
// terminal count rather than wrapping.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   clr   - synchronous clear to 0 (has priority over en)
//   en    - advance the count by one
//   count - current count
//   tc    - high while count == CHAIN_LEN-1 (last cycle of a pass)
module scan_bit_counter #(
  parameter int CHAIN_LEN = 8,
  localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  assign tc = (count == CNT_W'(CHAIN_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/scan_chain_driver.sv
// scan_chain_driver
// Loads a parallel pattern into a mux-scan flop chain, pulses one
// functional capture cycle, then unloads the chain into a parallel
// response word.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - request one operation (only honoured in IDLE)
//   pattern  - parallel pattern, sampled on the accepting edge
//   so       - serial output of the last chain flop
//   sc       - scan enable to the chain (1 = shift, 0 = capture)
//   sd       - serial data into the first chain flop
//   busy     - operation in progress
//   done     - one-cycle pulse, response valid
//   response - captured chain contents, held until the next done
module scan_chain_driver
  import scan_drv_pkg::*;
#(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic                 so,
  output logic                 sc,
  output logic                 sd,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  state_t               state_reg, state_next;
  logic [CHAIN_LEN-1:0] shift_reg, shift_next;
  logic [CHAIN_LEN-1:0] build_reg, build_next;
  logic [CHAIN_LEN-1:0] response_reg, response_next;
  logic                 sc_reg, sc_next;
  logic                 sd_reg, sd_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] shift_in;

  scan_bit_counter #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(cnt),
    .tc   (cnt_tc)
  );

  // Response builder takes so in at the LSB; the first sample (last flop)
  // ends at the MSB. The cast drops the oldest bit and also covers N=1.
  assign shift_in = CHAIN_LEN'({build_reg, so});

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    build_next    = build_reg;
    response_next = response_reg;
    sc_next       = 1'b0;
    sd_next       = 1'b0;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          // The MSB goes out in the first shift cycle, so register it now
          // and keep the remaining bits for the following cycles.
          state_next = SHIFT;
          sc_next    = 1'b1;
          sd_next    = pattern[CHAIN_LEN-1];
          shift_next = pattern << 1;
          cnt_clr    = 1'b1;
          busy_next  = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_tc) begin
          state_next = CAPTURE;
        end else begin
          sc_next    = 1'b1;
          sd_next    = shift_reg[CHAIN_LEN-1];
          shift_next = shift_reg << 1;
          cnt_en     = 1'b1;
        end
      end
      CAPTURE: begin
        state_next = UNLOAD;
        sc_next    = 1'b1;
        cnt_clr    = 1'b1;
      end
      UNLOAD: begin
        build_next = shift_in;
        if (cnt_tc) begin
          state_next    = IDLE;
          response_next = shift_in;
          done_next     = 1'b1;
          busy_next     = 1'b0;
        end else begin
          sc_next = 1'b1;
          cnt_en  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      build_reg    <= '0;
      response_reg <= '0;
      sc_reg       <= 1'b0;
      sd_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      build_reg    <= build_next;
      response_reg <= response_next;
      sc_reg       <= sc_next;
      sd_reg       <= sd_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign sc       = sc_reg;
  assign sd       = sd_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign response = response_reg;

endmodule

// File: tb/tb_scan_chain_driver.sv
// tb_scan_chain_driver
// Directed bench for scan_chain_driver with behavioural mux-scan chain
// models: an 8-flop chain and a 1-flop chain, each with selectable
// functional input (hold or invert).
module tb_scan_chain_driver;

  logic       clk = 1'b0;
  logic       rst;
  // 8-flop instance
  logic       start;
  logic [7:0] pattern;
  logic       so, sc, sd, busy, done;
  logic [7:0] response;
  logic [7:0] chain;
  logic       inv;
  // 1-flop instance
  logic       start1;
  logic [0:0] pattern1;
  logic       so1, sc1, sd1, busy1, done1;
  logic [0:0] response1;
  logic       chain1;
  logic       inv1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_chain_driver #(.CHAIN_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .so(so),
    .sc(sc), .sd(sd), .busy(busy), .done(done), .response(response)
  );

  scan_chain_driver #(.CHAIN_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pattern(pattern1), .so(so1),
    .sc(sc1), .sd(sd1), .busy(busy1), .done(done1), .response(response1)
  );

  // Mux-scan chain: shift toward the last flop (chain[7]) when sc=1,
  // otherwise load the functional input d = q or d = ~q.
  always @(posedge clk) begin
    if (sc) chain <= {chain[6:0], sd};
    else    chain <= inv ? ~chain : chain;
    if (sc1) chain1 <= sd1;
    else     chain1 <= inv1 ? ~chain1 : chain1;
  end
  assign so  = chain[7];
  assign so1 = chain1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation on the 8-flop instance, sampled at every negedge.
  // restart_at > 0 pulses start again in that busy cycle.
  task automatic run_op(input logic [7:0] pat, input logic [7:0] exp_resp,
                        input int restart_at, input string tag);
    logic [19:0] sc_s, sc_e, busy_s, busy_e, done_s, done_e;
    logic [7:0]  sd_s, sd_u;
    @(negedge clk);
    pattern = pat;
    start   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start   = 1'b0;
        pattern = 8'hFF;
      end
      if (i == restart_at)     start = 1'b1;
      if (i == restart_at + 1) start = 1'b0;
      sc_s[i-1]   = sc;
      busy_s[i-1] = busy;
      done_s[i-1] = done;
      sc_e[i-1]   = (i <= 8) || (i >= 10 && i <= 17);
      busy_e[i-1] = (i <= 17);
      done_e[i-1] = (i == 18);
      if (i <= 8) sd_s[8-i] = sd;
      if (i >= 10 && i <= 17) sd_u[17-i] = sd;
      if (i == 18) chk({tag, " response@done"}, response, exp_resp);
    end
    chk({tag, " sd shift seq"}, sd_s, pat);
    chk({tag, " sd unload zero"}, sd_u, 8'h00);
    chk({tag, " sc seq"}, sc_s, sc_e);
    chk({tag, " busy seq"}, busy_s, busy_e);
    chk({tag, " done seq"}, done_s, done_e);
    chk({tag, " response held"}, response, exp_resp);
  endtask

  initial begin
    logic done_seen;
    int   done_cnt;
    rst = 1'b1; start = 1'b0; pattern = 8'h00; inv = 1'b0;
    start1 = 1'b0; pattern1 = 1'b0; inv1 = 1'b0;
    #2;
    chk("reset sc", sc, 1'b0);
    chk("reset sd", sd, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset response", response, 8'h00);
    chk("reset response1", response1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Hold chain: response equals pattern
    $display("op: hold chain, pattern A5");
    inv = 1'b0;
    run_op(8'hA5, 8'hA5, 0, "hold A5");

    // Inverting chain
    $display("op: invert chain, pattern A5");
    inv = 1'b1;
    run_op(8'hA5, 8'h5A, 0, "invert A5");

    // Start while busy ignored
    $display("op: hold chain, pattern A5, restart at k+5");
    inv = 1'b0;
    run_op(8'hA5, 8'hA5, 5, "busy restart");

    // Reset mid-SHIFT
    $display("op: reset at k+4 mid-shift");
    @(negedge clk);
    pattern = 8'hA5;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset sc", sc, 1'b1);
    rst = 1'b1;
    #1;
    chk("async rst sc", sc, 1'b0);
    chk("async rst sd", sd, 1'b0);
    chk("async rst busy", busy, 1'b0);
    chk("async rst response", response, 8'h00);
    done_seen = done;
    repeat (3) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    chk("no done after rst", done_seen, 1'b0);
    run_op(8'h3C, 8'h3C, 0, "post-rst 3C");

    // Start held across done: second op starts in the done cycle
    $display("op: start held across done, 96 then 69");
    done_cnt = 0;
    @(negedge clk);
    pattern = 8'h96;
    start   = 1'b1;
    for (int i = 1; i <= 38; i++) begin
      @(negedge clk);
      if (i == 1) pattern = 8'h69;
      if (i == 19) start = 1'b0;
      if (done) done_cnt++;
      if (i == 17) chk("held busy@17", busy, 1'b1);
      if (i == 18) begin
        chk("held busy@18", busy, 1'b0);
        chk("held done@18", done, 1'b1);
        chk("held resp1", response, 8'h96);
      end
      if (i == 19) begin
        chk("held busy@19", busy, 1'b1);
        chk("held sc@19", sc, 1'b1);
        chk("held sd@19", sd, 1'b0);
      end
      if (i == 36) begin
        chk("held done@36", done, 1'b1);
        chk("held resp2", response, 8'h69);
      end
    end
    chk("held done count", done_cnt, 2);

    // CHAIN_LEN=1: hold then invert
    for (int t = 0; t < 2; t++) begin
      $display("op: 1-flop chain, inv=%0d, pattern 1", t);
      inv1 = (t == 1);
      @(negedge clk);
      pattern1 = 1'b1;
      start1   = 1'b1;
      for (int i = 1; i <= 5; i++) begin
        @(negedge clk);
        if (i == 1) begin
          start1   = 1'b0;
          pattern1 = 1'b0;
          chk("n1 sc@1", sc1, 1'b1);
          chk("n1 sd@1", sd1, 1'b1);
        end
        if (i == 2) chk("n1 sc@2", sc1, 1'b0);
        if (i == 3) begin
          chk("n1 sc@3", sc1, 1'b1);
          chk("n1 busy@3", busy1, 1'b1);
        end
        if (i == 4) begin
          chk("n1 done@4", done1, 1'b1);
          chk("n1 busy@4", busy1, 1'b0);
          chk("n1 response", response1, (t == 1) ? 1'b0 : 1'b1);
        end
        if (i == 5) chk("n1 done@5", done1, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
